// File: rtl/el2_exu_mul_wb_ctl.sv
// Writeback staging FIFO behind the multiplier: captures X-stage results and
// drains them to the shared GPR writeback port with valid/ready handshaking.
module el2_exu_mul_wb_ctl #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mul_valid_x,
  input  logic [4:0]               mul_rd_x,
  input  logic [31:0]              result_x,
  input  logic                     flush_x,
  input  logic                     wb_ready,
  output logic                     wb_valid,
  output logic [4:0]               wb_rd,
  output logic [31:0]              wb_data,
  output logic                     mul_stall,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_q;

  logic full;
  logic enq_req;
  logic deq;
  logic enq;
  logic drop;

  assign full    = (count == CW'(DEPTH));
  assign enq_req = mul_valid_x & ~flush_x & (mul_rd_x != 5'd0);
  assign deq     = wb_valid & wb_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign enq     = enq_req & (~full | deq);
  assign drop    = enq_req & full & ~deq;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= drop;
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately unreset; outputs mask it while invalid.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      rd_mem[wr_ptr]   <= mul_rd_x;
      data_mem[wr_ptr] <= result_x;
    end
  end

  assign wb_valid     = (count != '0);
  assign wb_rd        = wb_valid ? rd_mem[rd_ptr] : 5'd0;
  assign wb_data      = wb_valid ? data_mem[rd_ptr] : 32'd0;
  assign mul_stall    = full;
  assign occupancy    = count;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_el2_exu_mul_wb_ctl.sv
// Directed self-checking bench for el2_exu_mul_wb_ctl with DEPTH = 2.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_el2_exu_mul_wb_ctl;

  logic        clk;
  logic        rst;
  logic        mul_valid_x;
  logic [4:0]  mul_rd_x;
  logic [31:0] result_x;
  logic        flush_x;
  logic        wb_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mul_stall;
  logic [1:0]  occupancy;
  logic        overflow_err;

  int tests_run;
  int tests_failed;

  el2_exu_mul_wb_ctl #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .mul_valid_x  (mul_valid_x),
    .mul_rd_x     (mul_rd_x),
    .result_x     (result_x),
    .flush_x      (flush_x),
    .wb_ready     (wb_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mul_stall    (mul_stall),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mul_valid_x = 1'b0;
    mul_rd_x    = 5'd0;
    result_x    = 32'd0;
    flush_x     = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    mul_valid_x = 1'b1;
    mul_rd_x    = rd;
    result_x    = data;
    flush_x     = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    wb_ready = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %0b want 0", wb_valid); end
    tests_run++;
    if (wb_rd !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_rd: got %0d want 0", wb_rd); end
    tests_run++;
    if (wb_data !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h want 0", wb_data); end
    tests_run++;
    if (mul_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %0b want 0", mul_stall); end
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_occ: got %0d want 0", occupancy); end
    tests_run++;
    if (overflow_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ovf: got %0b want 0", overflow_err); end
  endtask

  task automatic test_basic_pass;
    wb_ready = 1'b1;
    push(5'd5, 32'h1234_5678);
    tests_run++;
    if (wb_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid: got %0b want 1", wb_valid); end
    tests_run++;
    if (wb_rd !== 5'd5) begin tests_failed++; $display("[TB] FAIL basic_rd: got %0d want 5", wb_rd); end
    tests_run++;
    if (wb_data !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL basic_data: got %h want 12345678", wb_data); end
    tests_run++;
    if (occupancy !== 2'd1) begin tests_failed++; $display("[TB] FAIL basic_occ1: got %0d want 1", occupancy); end
    tick();
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL basic_occ0: got %0d want 0", occupancy); end
    tests_run++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL basic_empty: got valid=%0b data=%h want 0/0", wb_valid, wb_data);
    end
  endtask

  task automatic test_fill_stall;
    wb_ready = 1'b0;
    push(5'd1, 32'h0000_0011);
    tests_run++;
    if (mul_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_stall_half: got %0b want 0", mul_stall); end
    push(5'd2, 32'h0000_0022);
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("[TB] FAIL fill_occ: got %0d want 2", occupancy); end
    tests_run++;
    if (mul_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_stall: got %0b want 1", mul_stall); end
    tick();
    tests_run++;
    if (wb_rd !== 5'd1 || wb_data !== 32'h11 || wb_valid !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL fill_hold: got v=%0b rd=%0d data=%h want 1/1/11", wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1;
    tests_run++;
    if (mul_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_no_ready_dep: got %0b want 1", mul_stall); end
    tick();
    tests_run++;
    if (wb_rd !== 5'd2 || wb_data !== 32'h22) begin
      tests_failed++; $display("[TB] FAIL fill_drain2: got rd=%0d data=%h want 2/22", wb_rd, wb_data);
    end
    tests_run++;
    if (occupancy !== 2'd1 || mul_stall !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fill_occ1: got occ=%0d stall=%0b want 1/0", occupancy, mul_stall);
    end
    tick();
    tests_run++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fill_empty: got occ=%0d valid=%0b want 0/0", occupancy, wb_valid);
    end
  endtask

  task automatic test_overflow;
    wb_ready = 1'b0;
    push(5'd1, 32'hAAAA_0001);
    push(5'd2, 32'hAAAA_0002);
    push(5'd3, 32'hDEAD_BEEF);
    tests_run++;
    if (overflow_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_pulse: got %0b want 1", overflow_err); end
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("[TB] FAIL ovf_occ: got %0d want 2", occupancy); end
    tests_run++;
    if (wb_rd !== 5'd1 || wb_data !== 32'hAAAA_0001) begin
      tests_failed++; $display("[TB] FAIL ovf_head: got rd=%0d data=%h want 1/aaaa0001", wb_rd, wb_data);
    end
    tick();
    tests_run++;
    if (overflow_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_one_cycle: got %0b want 0", overflow_err); end
    wb_ready = 1'b1;
    push(5'd3, 32'h0000_0333);
    tests_run++;
    if (overflow_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_deq_ovf: got %0b want 0", overflow_err); end
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("[TB] FAIL full_deq_occ: got %0d want 2", occupancy); end
    tests_run++;
    if (wb_rd !== 5'd2 || wb_data !== 32'hAAAA_0002) begin
      tests_failed++; $display("[TB] FAIL full_deq_head: got rd=%0d data=%h want 2/aaaa0002", wb_rd, wb_data);
    end
    tick();
    tests_run++;
    if (wb_rd !== 5'd3 || wb_data !== 32'h0000_0333) begin
      tests_failed++; $display("[TB] FAIL full_deq_next: got rd=%0d data=%h want 3/333", wb_rd, wb_data);
    end
    tick();
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL ovf_drain: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush_x0;
    wb_ready = 1'b0;
    push(5'd7, 32'h0000_0777);
    mul_valid_x = 1'b1; mul_rd_x = 5'd8; result_x = 32'h888; flush_x = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (occupancy !== 2'd1 || overflow_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL flush_noenq: got occ=%0d ovf=%0b want 1/0", occupancy, overflow_err);
    end
    tests_run++;
    if (wb_rd !== 5'd7 || wb_data !== 32'h777) begin
      tests_failed++; $display("[TB] FAIL flush_keeps_head: got rd=%0d data=%h want 7/777", wb_rd, wb_data);
    end
    push(5'd0, 32'h0000_0999);
    tests_run++;
    if (occupancy !== 2'd1 || overflow_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL x0_noenq: got occ=%0d ovf=%0b want 1/0", occupancy, overflow_err);
    end
    push(5'd9, 32'h0000_0999);
    push(5'd0, 32'h0000_0123);
    tests_run++;
    if (occupancy !== 2'd2 || overflow_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL x0_full_no_ovf: got occ=%0d ovf=%0b want 2/0", occupancy, overflow_err);
    end
    mul_valid_x = 1'b1; mul_rd_x = 5'd4; result_x = 32'h444; flush_x = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (occupancy !== 2'd2 || overflow_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL flush_full_no_ovf: got occ=%0d ovf=%0b want 2/0", occupancy, overflow_err);
    end
    wb_ready = 1'b1;
    tick();
    tests_run++;
    if (wb_rd !== 5'd9 || wb_data !== 32'h999) begin
      tests_failed++; $display("[TB] FAIL flush_order: got rd=%0d data=%h want 9/999", wb_rd, wb_data);
    end
    tick();
  endtask

  task automatic test_wrap;
    int next_issue;
    int next_expect;
    int cyc;
    logic issued;
    next_issue  = 1;
    next_expect = 1;
    cyc         = 0;
    while (next_expect <= 10 && cyc < 100) begin
      wb_ready = cyc[0];
      issued   = 1'b0;
      if (next_issue <= 10 && !mul_stall) begin
        mul_valid_x = 1'b1;
        mul_rd_x    = 5'(next_issue);
        result_x    = 32'hC0DE_0000 + 32'(next_issue);
        issued      = 1'b1;
      end else begin
        idle_inputs();
      end
      if (wb_valid && wb_ready) begin
        tests_run++;
        if (wb_rd !== 5'(next_expect) || wb_data !== 32'hC0DE_0000 + 32'(next_expect)) begin
          tests_failed++;
          $display("[TB] FAIL wrap_order: got rd=%0d data=%h want %0d/%h", wb_rd, wb_data,
                   next_expect, 32'hC0DE_0000 + 32'(next_expect));
        end
        next_expect++;
      end
      tick();
      if (issued) next_issue++;
      tests_run++;
      if (occupancy > 2'd2 || overflow_err !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL wrap_bounds: got occ=%0d ovf=%0b want <=2/0", occupancy, overflow_err);
      end
      cyc++;
    end
    idle_inputs();
    tests_run++;
    if (next_expect != 11) begin
      tests_failed++; $display("[TB] FAIL wrap_complete: got %0d drained want 10", next_expect - 1);
    end
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL wrap_final_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid;
    wb_ready = 1'b0;
    push(5'd11, 32'h0000_0B0B);
    push(5'd12, 32'h0000_0C0C);
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("[TB] FAIL rstmid_pre_occ: got %0d want 2", occupancy); end
    rst         = 1'b1;
    wb_ready    = 1'b1;
    mul_valid_x = 1'b1; mul_rd_x = 5'd4; result_x = 32'h0000_0404;
    tick();
    rst = 1'b0;
    idle_inputs();
    tests_run++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin
      tests_failed++; $display("[TB] FAIL rstmid_out: got v=%0b rd=%0d data=%h want 0/0/0", wb_valid, wb_rd, wb_data);
    end
    tests_run++;
    if (occupancy !== 2'd0 || mul_stall !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rstmid_state: got occ=%0d stall=%0b want 0/0", occupancy, mul_stall);
    end
    tick();
    tests_run++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rstmid_after: got occ=%0d valid=%0b want 0/0", occupancy, wb_valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    wb_ready     = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_pass();
    test_fill_stall();
    test_overflow();
    test_flush_x0();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
